// File: rtl/systolic_gemm_tile_pkg.sv
// Shared definitions for the systolic GEMM tile: FSM states, default sizes and
// the output saturation helper.
package systolic_gemm_tile_pkg;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 4;
  localparam int DEF_DW   = 8;
  localparam int DEF_ACCW = 24;
  localparam int DEF_CW   = 16;
  localparam int DEF_KMAX = 255;

  // Wide enough to hold any legal accumulator before narrowing to CW.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Clamp v into the signed cw-bit range when sat_on is set; otherwise pass it
  // through so the caller's truncation to cw bits gives wrap behaviour.
  function automatic logic signed [SAT_W-1:0] sat_value(
    input logic signed [SAT_W-1:0] v,
    input int                      cw,
    input logic                    sat_on
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (cw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (cw - 1));
    if (sat_on && (v > hi)) return hi;
    if (sat_on && (v < lo)) return lo;
    return v;
  endfunction

endpackage

// File: rtl/systolic_gemm_tile_pe.sv
// One processing element: forwards A right and B down with their valid bits
// and accumulates a*b whenever both operands arriving this cycle are valid.
module gemm_pe
  import systolic_gemm_tile_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int ACCW = DEF_ACCW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [DW-1:0]          a_in,
  input  logic                   a_vin,
  input  logic [DW-1:0]          b_in,
  input  logic                   b_vin,
  output logic [DW-1:0]          a_out,
  output logic                   a_vout,
  output logic [DW-1:0]          b_out,
  output logic                   b_vout,
  output logic signed [ACCW-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;

  assign prod     = $signed(a_in) * $signed(b_in);
  assign prod_ext = ACCW'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out  <= '0;
      a_vout <= 1'b0;
      b_out  <= '0;
      b_vout <= 1'b0;
      acc    <= '0;
    end else begin
      a_out  <= a_in;
      a_vout <= a_vin;
      b_out  <= b_in;
      b_vout <= b_vin;
      if (clear) acc <= '0;
      else if (a_vin && b_vin) acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_gemm_tile.sv
// ROWS x COLS output-stationary systolic GEMM tile: skewed A columns and B rows
// stream through a PE grid; results are read from the accumulators after DONE.
module systolic_gemm_tile
  import systolic_gemm_tile_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int DW   = DEF_DW,
  parameter int ACCW = DEF_ACCW,
  parameter int CW   = DEF_CW,
  parameter int KMAX = DEF_KMAX
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(KMAX+1)-1:0]    k_len,
  input  logic                         acc_keep,
  input  logic                         sat_en,
  input  logic [ROWS*DW-1:0]           a_col_flat,
  input  logic [COLS*DW-1:0]           b_row_flat,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [ROWS*COLS*CW-1:0]      c_flat,
  output logic                         busy,
  output logic                         done
);

  localparam int KW  = $clog2(KMAX + 1);
  localparam int DCW = $clog2(ROWS + COLS);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(ROWS + COLS - 2);

  state_t         state;
  logic [KW-1:0]  k_q;
  logic [KW-1:0]  beat_cnt;
  logic [DCW-1:0] drain_cnt;
  logic           sat_q;
  logic           beat_v;
  logic           clear;

  // Handshake: a beat moves on a rising edge where in_valid and in_ready are
  // both high; in_ready is registered and is high only in LOAD.
  assign beat_v = in_valid && in_ready;
  assign clear  = (state == S_IDLE) && start && !acc_keep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k_q       <= '0;
      sat_q     <= 1'b0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            k_q      <= k_len;
            sat_q    <= sat_en;
            beat_cnt <= '0;
            busy     <= 1'b1;
            if (k_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt == k_q - KW'(1)) begin
              state     <= S_DRAIN;
              in_ready  <= 1'b0;
              drain_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          // The last beat reaches PE(ROWS-1,COLS-1) ROWS+COLS-2 edges later.
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  logic [DW-1:0]          a_bus  [ROWS][COLS+1];
  logic                   a_vbus [ROWS][COLS+1];
  logic [DW-1:0]          b_bus  [ROWS+1][COLS];
  logic                   b_vbus [ROWS+1][COLS];
  logic signed [ACCW-1:0] acc_bus [ROWS*COLS];

  for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
    if (i == 0) begin : g_direct
      assign a_bus[i][0]  = a_col_flat[i*DW +: DW];
      assign a_vbus[i][0] = beat_v;
    end else begin : g_regs
      logic [DW-1:0] d [i];
      logic          v [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < i; s++) begin
            d[s] <= '0;
            v[s] <= 1'b0;
          end
        end else begin
          d[0] <= a_col_flat[i*DW +: DW];
          v[0] <= beat_v;
          for (int s = 1; s < i; s++) begin
            d[s] <= d[s-1];
            v[s] <= v[s-1];
          end
        end
      end
      assign a_bus[i][0]  = d[i-1];
      assign a_vbus[i][0] = v[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b_skew
    if (j == 0) begin : g_direct
      assign b_bus[0][j]  = b_row_flat[j*DW +: DW];
      assign b_vbus[0][j] = beat_v;
    end else begin : g_regs
      logic [DW-1:0] d [j];
      logic          v [j];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < j; s++) begin
            d[s] <= '0;
            v[s] <= 1'b0;
          end
        end else begin
          d[0] <= b_row_flat[j*DW +: DW];
          v[0] <= beat_v;
          for (int s = 1; s < j; s++) begin
            d[s] <= d[s-1];
            v[s] <= v[s-1];
          end
        end
      end
      assign b_bus[0][j]  = d[j-1];
      assign b_vbus[0][j] = v[j-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      gemm_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .a_in   (a_bus[r][c]),
        .a_vin  (a_vbus[r][c]),
        .b_in   (b_bus[r][c]),
        .b_vin  (b_vbus[r][c]),
        .a_out  (a_bus[r][c+1]),
        .a_vout (a_vbus[r][c+1]),
        .b_out  (b_bus[r+1][c]),
        .b_vout (b_vbus[r+1][c]),
        .acc    (acc_bus[r*COLS+c])
      );
    end
  end

  always_comb begin
    c_flat = '0;
    for (int n = 0; n < ROWS*COLS; n++) begin
      c_flat[n*CW +: CW] = CW'(sat_value(SAT_W'(acc_bus[n]), CW, sat_q));
    end
  end

endmodule

// File: tb/tb_systolic_gemm_tile.sv
// Bench for systolic_gemm_tile: a job table drives whole GEMM jobs, a reference
// model fills the expected queue, and results are popped when done pulses.
module tb_systolic_gemm_tile;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int ACCW = 24;
  localparam int CW   = 16;
  localparam int KMAX = 255;
  localparam int KW   = 8;
  localparam int KBUF = 32;
  localparam int NREC = 16;

  localparam int P_ID = 0, P_POS = 1, P_NEGPOS = 2, P_RAND = 3, P_SAME = 4;
  localparam int M_JOB = 0, M_RST = 1;

  typedef struct {
    int          k;
    bit          keep;
    bit          sat;
    int          gap;    // 0 none, 1 alternate cycles, 2 random
    int          pat;
    int          off;    // first beat index into the operand arrays
    int          mode;
    int          lat;    // edges from the accepting edge to done high
    bit          use_c;
    logic [15:0] cval;
  } rec_t;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic [KW-1:0]           k_len;
  logic                    acc_keep;
  logic                    sat_en;
  logic [ROWS*DW-1:0]      a_col_flat;
  logic [COLS*DW-1:0]      b_row_flat;
  logic                    in_valid;
  logic                    in_ready;
  logic [ROWS*COLS*CW-1:0] c_flat;
  logic                    busy;
  logic                    done;

  systolic_gemm_tile #(
    .ROWS(ROWS), .COLS(COLS), .DW(DW), .ACCW(ACCW), .CW(CW), .KMAX(KMAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .k_len      (k_len),
    .acc_keep   (acc_keep),
    .sat_en     (sat_en),
    .a_col_flat (a_col_flat),
    .b_row_flat (b_row_flat),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .c_flat     (c_flat),
    .busy       (busy),
    .done       (done)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int            n_checks;
  int            n_fail;
  logic [CW-1:0] exp_q[$];
  longint        macc [ROWS][COLS];
  int            a_m [ROWS][KBUF];
  int            b_m [KBUF][COLS];
  rec_t          tbl [NREC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint wrap_acc(input longint v);
    longint m;
    m = v & ((longint'(1) <<< ACCW) - 1);
    if (m >= (longint'(1) <<< (ACCW - 1))) m = m - (longint'(1) <<< ACCW);
    return m;
  endfunction

  task automatic gen_data(input int pat);
    for (int k = 0; k < KBUF; k++) begin
      for (int i = 0; i < ROWS; i++) begin
        case (pat)
          P_ID:     a_m[i][k] = (i == k) ? 1 : 0;
          P_POS:    a_m[i][k] = 127;
          P_NEGPOS: a_m[i][k] = -128;
          default:  a_m[i][k] = int'($urandom_range(0, 255)) - 128;
        endcase
      end
      for (int j = 0; j < COLS; j++) begin
        case (pat)
          P_ID:     b_m[k][j] = k * COLS + j;
          P_POS:    b_m[k][j] = 127;
          P_NEGPOS: b_m[k][j] = 127;
          default:  b_m[k][j] = int'($urandom_range(0, 255)) - 128;
        endcase
      end
    end
  endtask

  // Reference model: accumulate the job into macc and queue the expected outputs.
  task automatic model_push(input rec_t r);
    longint v;
    if (!r.keep) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) macc[i][j] = 0;
    end
    for (int k = r.off; k < r.off + r.k; k++)
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          macc[i][j] = wrap_acc(macc[i][j] + longint'(a_m[i][k]) * longint'(b_m[k][j]));
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        v = macc[i][j];
        if (r.sat && v > 32767) v = 32767;
        if (r.sat && v < -32768) v = -32768;
        exp_q.push_back(r.use_c ? r.cval : CW'(v));
      end
    end
  endtask

  task automatic drive_beat(input int idx, input logic v);
    in_valid = v;
    for (int i = 0; i < ROWS; i++)
      a_col_flat[i*DW +: DW] = v ? DW'(a_m[i][idx]) : DW'($urandom);
    for (int j = 0; j < COLS; j++)
      b_row_flat[j*DW +: DW] = v ? DW'(b_m[idx][j]) : DW'($urandom);
  endtask

  // Called and returns at a falling edge.
  task automatic run_job(input rec_t r);
    int                      b;
    int                      cyc;
    int                      lat;
    int                      busy_bad;
    int                      rdy_seen;
    logic                    rdy;
    logic                    v;
    logic [CW-1:0]           e;
    logic [ROWS*COLS*CW-1:0] exp_flat;
    model_push(r);
    start    = 1'b1;
    k_len    = KW'(r.k);
    acc_keep = r.keep;
    sat_en   = r.sat;
    @(negedge clk);
    start    = 1'b0;
    k_len    = KW'($urandom);
    acc_keep = 1'($urandom);
    sat_en   = 1'($urandom);
    check("busy_after_start", 64'(busy), 64'(1));
    b = 0; cyc = 0; busy_bad = 0; rdy_seen = 0;
    while (b < r.k && cyc < 1000) begin
      case (r.gap)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      drive_beat(r.off + b, v);
      rdy = in_ready;
      if (!busy) busy_bad++;
      @(negedge clk);
      if (v && rdy) b++;
      cyc++;
    end
    drive_beat(0, 1'b0);
    check("beats_accepted", 64'(b), 64'(r.k));
    lat = 0;
    while (!done && lat < 64) begin
      if (!busy) busy_bad++;
      if (in_ready) rdy_seen++;
      @(negedge clk);
      lat++;
    end
    check("done_latency", 64'(lat), 64'(r.lat));
    check("busy_held", 64'(busy_bad), 64'(0));
    check("ready_after_load", 64'(rdy_seen), 64'(0));
    exp_flat = '0;
    for (int n = 0; n < ROWS*COLS; n++) begin
      if (exp_q.size() == 0) begin
        check("exp_q_underflow", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        exp_flat[n*CW +: CW] = e;
        check($sformatf("c_%0d_%0d", n / COLS, n % COLS), 64'(c_flat[n*CW +: CW]), 64'(e));
      end
    end
    // start coinciding with done must be ignored; so must in_valid in IDLE.
    start    = 1'b1;
    k_len    = '0;
    acc_keep = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_pulse_width", 64'(done), 64'(0));
    check("start_ignored_at_done", 64'(busy), 64'(0));
    @(negedge clk);
    in_valid = 1'b0;
    check("idle_in_valid_ignored", 64'({busy, in_ready}), 64'(0));
    check("c_flat_held", 64'(c_flat == exp_flat), 64'(1));
  endtask

  // Reset in the middle of LOAD; returns at the falling edge where rst_n rises.
  task automatic run_reset();
    start    = 1'b1;
    k_len    = KW'(8);
    acc_keep = 1'b1;
    sat_en   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive_beat(b, 1'b1);
      @(negedge clk);
    end
    check("busy_before_reset", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    drive_beat(0, 1'b0);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_c_flat_zero", 64'(c_flat == '0), 64'(1));
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) macc[i][j] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //            k  keep sat gap pat       off mode   lat use_c cval
    tbl[0]  = '{4,  0, 0, 0, P_ID,     0, M_JOB, 7, 0, 16'h0000};
    tbl[1]  = '{4,  0, 0, 1, P_ID,     0, M_JOB, 7, 0, 16'h0000};
    tbl[2]  = '{8,  0, 1, 0, P_POS,    0, M_JOB, 7, 1, 16'h7FFF};
    tbl[3]  = '{8,  0, 1, 2, P_NEGPOS, 0, M_JOB, 7, 1, 16'h8000};
    tbl[4]  = '{8,  0, 0, 0, P_POS,    0, M_JOB, 7, 1, 16'hF808};
    tbl[5]  = '{8,  0, 0, 0, P_NEGPOS, 0, M_JOB, 7, 0, 16'h0000};
    tbl[6]  = '{2,  0, 0, 0, P_RAND,   0, M_JOB, 7, 0, 16'h0000};
    tbl[7]  = '{2,  1, 0, 1, P_SAME,   2, M_JOB, 7, 0, 16'h0000};
    tbl[8]  = '{4,  0, 0, 0, P_SAME,   0, M_JOB, 7, 0, 16'h0000};
    tbl[9]  = '{0,  0, 0, 0, P_SAME,   0, M_JOB, 0, 1, 16'h0000};
    tbl[10] = '{5,  0, 1, 2, P_RAND,   0, M_JOB, 7, 0, 16'h0000};
    tbl[11] = '{3,  1, 0, 0, P_RAND,   0, M_JOB, 7, 0, 16'h0000};
    tbl[12] = '{8,  1, 0, 0, P_RAND,   0, M_RST, 0, 0, 16'h0000};
    tbl[13] = '{4,  0, 0, 0, P_ID,     0, M_JOB, 7, 0, 16'h0000};
    tbl[14] = '{20, 0, 1, 2, P_RAND,   0, M_JOB, 7, 0, 16'h0000};
    tbl[15] = '{2,  1, 0, 1, P_RAND,   0, M_JOB, 7, 0, 16'h0000};

    // Clock/reset: a definite falling edge on rst_n, checked before any clock edge.
    rst_n      = 1'b1;
    start      = 1'b0;
    k_len      = '0;
    acc_keep   = 1'b0;
    sat_en     = 1'b0;
    in_valid   = 1'b0;
    a_col_flat = '0;
    b_row_flat = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) macc[i][j] = 0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(0));
    check("reset_c_flat", 64'(c_flat == '0), 64'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < NREC; t++) begin
      if (tbl[t].pat != P_SAME) gen_data(tbl[t].pat);
      if (tbl[t].mode == M_RST) run_reset();
      else run_job(tbl[t]);
    end

    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
